bram_axis_reader: RTL and testbench
===================================

Name: bram_axis_reader

Overview:
- Read-side companion of the team's simple dual-port BRAM.
- On a start command, drives the BRAM read port (addrb/enb, 1-cycle read latency) over a contiguous address range.
- Streams the words out as an AXI4-Stream master, with tlast on the final beat.
- Sustains 1 beat/cycle and absorbs arbitrary tready backpressure with no lost or duplicated words.

Parameters:
- DATA_WIDTH, 32, width of BRAM words and m_axis_tdata.
- RAM_DEPTH, 512, number of BRAM words; must match the attached BRAM.
- ADDR_WIDTH, 9, BRAM address width; equals ceil(log2(RAM_DEPTH)).

Ports:
- aclk  in  1  single clock, shared with the BRAM.
- aresetn  in  1  synchronous, active-low reset.
- start  in  1  single-cycle command strobe; sampled only when busy=0.
- start_addr  in  ADDR_WIDTH  first BRAM address to read.
- length  in  ADDR_WIDTH+1  number of words, 1..RAM_DEPTH.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at transfer completion.
- bram_addrb  out  ADDR_WIDTH  BRAM read address.
- bram_enb  out  1  BRAM read enable.
- bram_doutb  in  DATA_WIDTH  BRAM read data; valid the cycle after bram_enb.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  marks the final word of the transfer.

Behaviour:
- Reset (aresetn=0 at a rising edge):
  - FSM goes to IDLE.
  - busy, done, bram_enb, m_axis_tvalid, m_axis_tlast = 0; bram_addrb, m_axis_tdata = 0.
  - Output buffer flushed, in-flight read discarded, counters cleared.
  - Reset mid-transfer aborts the transfer: no done pulse, no further beats.
- FSM states and transitions:
  - IDLE → RUN on start=1 with length≠0; latches rd_addr=start_addr, issue_cnt=length, beat_cnt=length; busy=1 from the next cycle.
  - start with length=0 is ignored: stays IDLE, no done pulse.
  - RUN: issues reads; → DRAIN when the last read is issued (issue_cnt reaches 0).
  - DRAIN: no reads; waits until the beat carrying tlast handshakes.
  - DONE: done=1 and busy=0 for exactly one cycle → IDLE.
  - start is accepted in the DONE cycle (busy=0 there); it is ignored while busy=1.
- Read issue:
  - Buffer is a 2-entry FIFO.
  - In RUN, bram_enb=1 in a cycle iff occ + inflight − (m_axis_tvalid & m_axis_tready) < 2, where inflight=1 if bram_enb was asserted the previous cycle.
  - On each issue: bram_addrb=rd_addr, rd_addr increments, issue_cnt decrements.
  - Address wraps modulo RAM_DEPTH; RAM_DEPTH=512, start_addr=510, length=4 reads 510, 511, 0, 1.
  - bram_enb=0 outside RUN.
- Data capture:
  - The cycle after bram_enb=1, bram_doutb is pushed into the FIFO.
  - The FIFO head drives m_axis_tdata; tvalid = FIFO not empty.
  - The credit rule guarantees the FIFO never overflows.
- Latency and throughput:
  - start sampled at edge 0 → first bram_enb in cycle 1 → data captured in cycle 2 → m_axis_tvalid=1 in cycle 3.
  - With tready held high: one beat per cycle, no bubbles.
- AXIS rules:
  - Once tvalid=1, tdata, tvalid and tlast are held stable until tready=1.
  - tvalid never depends combinationally on tready.
  - Simultaneous push and pop in one cycle is legal; occupancy stays unchanged.
- tlast:
  - Asserted on the beat where beat_cnt=1; beat_cnt decrements per handshake.
  - length=1: the single beat carries tlast.
- done: asserted in the cycle after the tlast handshake.

Test Plan:
- BRAM preloaded with mem[i]=i; start_addr=0x010, length=8, tready=1 → tvalid first at cycle 3; tdata 0x10..0x17 on consecutive cycles; tlast on 0x17; done one cycle later.
- Same transfer with tready toggling 1,0,0,1 repeating → same 8 values in order, no duplicates; tdata stable while tready=0; bram_enb never pushes the FIFO past 2 entries.
- start_addr=510, length=4 → bram_addrb sequence 510, 511, 0, 1; tdata 510, 511, 0, 1; tlast on value 1.
- length=1 at addr 5 → single beat with tdata=5 and tlast=1; length=0 → no busy, no beats, no done; start asserted while busy → ignored, beat count unchanged.
- aresetn=0 for 1 cycle after the 3rd beat of a length=8 transfer → tvalid=0 and busy=0 next cycle, no done; a subsequent start, addr 0, length=2 → beats 0, 1 with tlast on 1.
- Back-to-back: start asserted in the done cycle with length=3, addr 100 → accepted; beats 100, 101, 102 follow.

Source files
------------

// File: rtl/bram_axis_reader.sv
// bram_axis_reader: reads a contiguous, wrapping address range from a
// simple dual-port BRAM (1-cycle read latency) and streams the words out as
// an AXI4-Stream master with tlast on the final beat. A 2-entry skid FIFO
// plus a credit check on read issue keeps full throughput under arbitrary
// backpressure without losing or duplicating words.
module bram_axis_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int RAM_DEPTH  = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  output logic                  bram_enb,
  input  logic [DATA_WIDTH-1:0] bram_doutb,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   beat_cnt;
  logic                  accept;
  logic                  pop;
  logic                  room;
  logic [2:0]            used;

  // Read pipeline stage: the valid flag travels one cycle behind bram_enb,
  // matching the BRAM read latency.
  logic                  rd_vld_p1;

  // Output skid FIFO (2 entries) feeding the stream.
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            occ;

  assign pop           = m_axis_tvalid & m_axis_tready;
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = fifo_mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt == (ADDR_WIDTH+1)'(1));
  assign bram_addrb    = rd_addr;

  // Words already buffered or in flight, less the one leaving this cycle,
  // must leave a free slot for a new read to land in.
  assign used = {1'b0, occ} + {2'b00, rd_vld_p1};
  assign room = used < (3'd2 + {2'b00, pop});

  // FSM state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state and control outputs.
  always_comb begin
    state_nxt = state;
    bram_enb  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if ((issue_cnt != '0) && room) begin
          bram_enb = 1'b1;
          if (issue_cnt == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && m_axis_tlast) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start && (length != '0)) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address and transfer counters: loaded on accept, stepped per issue/beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_addr   <= '0;
      issue_cnt <= '0;
      beat_cnt  <= '0;
    end else if (accept) begin
      rd_addr   <= start_addr;
      issue_cnt <= length;
      beat_cnt  <= length;
    end else begin
      if (bram_enb) begin
        rd_addr   <= (rd_addr == ADDR_WIDTH'(RAM_DEPTH-1)) ? '0 : rd_addr + 1'b1;
        issue_cnt <= issue_cnt - 1'b1;
      end
      if (pop) beat_cnt <= beat_cnt - 1'b1;
    end
  end

  // Capture returning BRAM data into the FIFO and retire handshaken beats.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_vld_p1   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      rd_vld_p1 <= bram_enb;
      if (rd_vld_p1) begin
        fifo_mem[wr_ptr] <= bram_doutb;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, rd_vld_p1} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_bram_axis_reader.sv
// Scoreboard bench for bram_axis_reader with a behavioural 1-cycle-latency
// BRAM preloaded with mem[i] = i.
module tb_bram_axis_reader;
  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int AW    = 9;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, bram_enb;
  logic [AW-1:0] bram_addrb;
  logic [DW-1:0] bram_doutb = '0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast;
  logic          m_axis_tready = 1'b1;

  bram_axis_reader #(.DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .start_addr(start_addr),
    .length(length), .busy(busy), .done(done), .bram_addrb(bram_addrb),
    .bram_enb(bram_enb), .bram_doutb(bram_doutb), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  logic [DW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
  always @(posedge aclk) if (bram_enb) bram_doutb <= mem[bram_addrb];

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard and monitor state.
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            hs_cyc_q [$];
  int            hs_cnt = 0, done_cnt = 0, issued_tot = 0, hs_tot = 0;
  int            first_vld_cyc = -1, last_hs_cyc = -100, t_start = 0;
  bit            busy_seen = 0, stall_prev = 0;
  logic [DW:0]   stall_word;
  logic [DW:0]   got;
  bit            pat_mode = 0;
  int            pidx = 0;

  always @(negedge aclk) begin
    if (aresetn) begin
      if (stall_prev)
        check_val("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_word});
      check_val("fifo_credit", 64'((issued_tot - hs_tot) <= 2), 64'd1);
      if (bram_enb) begin
        addr_q.push_back(bram_addrb);
        issued_tot++;
      end
      if (m_axis_tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        hs_cnt++;
        hs_tot++;
        hs_cyc_q.push_back(cyc);
        check_val("beat_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          got = exp_q.pop_front();
          check_val("beat", {m_axis_tlast, m_axis_tdata}, got);
        end
        if (m_axis_tlast) last_hs_cyc = cyc;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      stall_word = {m_axis_tlast, m_axis_tdata};
      if (busy) busy_seen = 1;
      if (done) begin
        done_cnt++;
        check_val("done_latency", 64'(cyc - last_hs_cyc), 64'd1);
      end
    end else begin
      stall_prev = 0;
      issued_tot = 0;
      hs_tot     = 0;
    end
  end

  // tready driver: constant high, or the repeating 1,0,0,1 pattern.
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    forever begin
      @(posedge aclk);
      #1;
      if (pat_mode) begin
        m_axis_tready = pat[pidx % 4];
        pidx++;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  task automatic push_exp(input int addr, input int len);
    for (int k = 0; k < len; k++)
      exp_q.push_back({(k == len - 1), DW'((addr + k) % DEPTH)});
  endtask

  task automatic pulse_start(input int addr, input int len);
    @(posedge aclk);
    #1;
    start_addr = AW'(addr);
    length     = (AW+1)'(len);
    start      = 1'b1;
    t_start    = cyc;
    @(posedge aclk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check_val({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    check_val({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int gaps;
    int hs0;
    int d0;
    int n;
    logic [AW-1:0] wrap_exp [4];

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    check_val("reset_outputs",
              {busy, done, bram_enb, m_axis_tvalid, m_axis_tlast, bram_addrb, m_axis_tdata},
              '0);
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);

    // Basic transfer with tready held high: latency and back-to-back beats.
    first_vld_cyc = -1;
    hs_cyc_q.delete();
    addr_q.delete();
    push_exp(16, 8);
    pulse_start(16, 8);
    wait_done("basic");
    check_val("first_valid_latency", 64'(first_vld_cyc - t_start), 64'd3);
    check_val("basic_beats", 64'(hs_cyc_q.size()), 64'd8);
    gaps = 0;
    for (int i = 1; i < hs_cyc_q.size(); i++)
      if (hs_cyc_q[i] != hs_cyc_q[i-1] + 1) gaps++;
    check_val("basic_no_bubbles", 64'(gaps), 64'd0);
    check_val("basic_first_enb", 64'(addr_q.size() != 0 ? addr_q[0] : '1), 64'd16);

    // Same transfer under 1,0,0,1 backpressure.
    pat_mode = 1;
    pidx     = 0;
    push_exp(16, 8);
    pulse_start(16, 8);
    wait_done("backpressure");
    pat_mode = 0;
    repeat (3) @(posedge aclk);

    // Address wrap at the top of the BRAM.
    addr_q.delete();
    wrap_exp[0] = 9'd510; wrap_exp[1] = 9'd511; wrap_exp[2] = 9'd0; wrap_exp[3] = 9'd1;
    push_exp(510, 4);
    pulse_start(510, 4);
    wait_done("wrap");
    check_val("wrap_reads", 64'(addr_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++)
      check_val("wrap_addr", 64'(addr_q[i]), 64'(wrap_exp[i]));

    // Single-word transfer.
    push_exp(5, 1);
    pulse_start(5, 1);
    wait_done("single");

    // Zero length is ignored.
    busy_seen = 0;
    hs0 = hs_cnt;
    d0  = done_cnt;
    pulse_start(7, 0);
    repeat (10) @(negedge aclk);
    check_val("zero_len_busy", 64'(busy_seen), 64'd0);
    check_val("zero_len_beats", 64'(hs_cnt - hs0), 64'd0);
    check_val("zero_len_done", 64'(done_cnt - d0), 64'd0);

    // start while busy is ignored.
    hs0 = hs_cnt;
    push_exp(40, 6);
    pulse_start(40, 6);
    @(posedge aclk);
    #1;
    start_addr = 9'd200;
    length     = 10'd5;
    start      = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    wait_done("busy_start");
    repeat (10) @(negedge aclk);
    check_val("busy_start_beats", 64'(hs_cnt - hs0), 64'd6);

    // Reset after the third beat aborts the transfer.
    hs0 = hs_cnt;
    push_exp(48, 8);
    pulse_start(48, 8);
    n = 0;
    while (hs_cnt - hs0 < 3 && n < 100) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check_val("abort_three_beats", 64'(hs_cnt - hs0), 64'd3);
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    check_val("abort_idle", {m_axis_tvalid, busy}, 64'd0);
    exp_q.delete();
    d0  = done_cnt;
    hs0 = hs_cnt;
    repeat (10) @(negedge aclk);
    check_val("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check_val("abort_no_beats", 64'(hs_cnt - hs0), 64'd0);
    push_exp(0, 2);
    pulse_start(0, 2);
    wait_done("after_abort");

    // Back-to-back: new start issued in the done cycle.
    push_exp(60, 3);
    pulse_start(60, 3);
    n = 0;
    while (!done && n < 100) begin
      @(negedge aclk);
      #1;
      n++;
    end
    check_val("b2b_done_seen", 64'(done), 64'd1);
    start_addr = 9'd100;
    length     = 10'd3;
    start      = 1'b1;
    push_exp(100, 3);
    @(posedge aclk);
    #1;
    start = 1'b0;
    check_val("b2b_accepted", 64'(busy), 64'd1);
    wait_done("b2b");

    repeat (5) @(posedge aclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
